fizzbuzz_sequencer: RTL and testbench
=====================================

Name: fizzbuzz_sequencer

Overview:
Run controller for the fizz/buzz classification datapath. It holds runtime-programmable divisors and run length, and sequences a run on start, with pause and abort. It emits one classification token per index over a valid/ready stream, so a downstream consumer can apply backpressure. It sits between the configuration/control host and any sink of the fizz/buzz token stream.

Parameters:
CNT_W, 8, width of the run-length register and the index counter.
DIV_W, 4, width of the divisor registers and the residue counters.
FIZZ_RST, 3, reset value of the fizz divisor.
BUZZ_RST, 5, reset value of the buzz divisor.
LEN_RST, 100, reset value of the run length (number of beats per run).

Ports:
clk  in  1  clock; all logic on rising edge.
resetn  in  1  asynchronous, active-low reset.
cfg_we  in  1  configuration write strobe.
cfg_fizz  in  DIV_W  fizz divisor to write.
cfg_buzz  in  DIV_W  buzz divisor to write.
cfg_len  in  CNT_W  run length to write.
start  in  1  start-run pulse.
abort  in  1  abort-run pulse.
pause  in  1  level; hold the run at the next beat boundary.
out_valid  out  1  token valid.
out_ready  in  1  sink ready.
out_index  out  CNT_W  index of the current token, 0..len-1.
out_code  out  2  token class: 00 none, 01 fizz, 10 buzz, 11 fizzbuzz.
busy  out  1  high in RUN or PAUSE.
done  out  1  one-cycle pulse when a run completes.
cfg_err  out  1  one-cycle pulse when a configuration write is rejected.

Behaviour:
- Reset (asynchronous, takes effect without a clock edge):
  - state=IDLE.
  - Config registers = FIZZ_RST/BUZZ_RST/LEN_RST.
  - out_valid=0, out_index=0, out_code=00, busy=0, done=0, cfg_err=0.
  - Residue counters = 0.
- Registered outputs: all outputs are registered, with no combinational input-to-output paths.
- States:
  - IDLE: out_valid=0, busy=0.
  - RUN: out_valid=1, busy=1.
  - PAUSE: out_valid=0, busy=1.
- Configuration:
  - A write is accepted only in IDLE and requires cfg_fizz!=0, cfg_buzz!=0 and cfg_len!=0.
  - Rejected write (busy, or any field zero): cfg_err pulses the next cycle and all three registers stay unchanged. There are no partial updates.
  - A divisor of 1 is legal; every index then matches that class.
- Start:
  - start in IDLE: RUN on the next cycle, with index=0 and both residues=0.
  - cfg_we and start in the same IDLE cycle: the accepted config applies to this run. If the write is rejected, the run uses the old values and cfg_err pulses.
  - start in RUN or PAUSE is ignored.
- Token encoding:
  - out_code[0] = (fizz residue==0).
  - out_code[1] = (buzz residue==0).
  - Index 0 is therefore always 11.
- Transfer: a transfer occurs when out_valid && out_ready.
  - On transfer, if index==len-1: go to IDLE, out_valid=0, done=1 for exactly one cycle (the cycle after the final transfer).
  - Otherwise: index+1; each residue +1, wrapping to 0 when it reaches divisor-1.
- Stall: while out_valid && !out_ready, out_index and out_code are held stable. Once raised, out_valid drops only on a transfer or an abort.
- Pause:
  - Sampled only on a transfer cycle. If pause=1 on a non-final transfer, go to PAUSE with the index and residues advanced.
  - In PAUSE, pause=0 returns to RUN on the next cycle and presents the next token.
  - pause on the final beat is ignored; done occurs normally.
- Abort:
  - abort in RUN or PAUSE: IDLE on the next cycle, out_valid=0, no done pulse.
  - If a transfer coincides with abort, the sink has consumed that beat, but the sequencer still aborts.
  - abort beats start in the same cycle. abort in IDLE has no effect.
- Arithmetic: index and len compare as CNT_W unsigned; no overflow is possible because len ≤ 2^CNT_W-1.

Test Plan:
1. Reset defaults, start, out_ready=1 constantly -> 100 beats with index 0..99 on consecutive cycles; codes at index 0=11, 3=01, 5=10, 7=00, 15=11, 99=01; done high for one cycle after beat 99; busy then 0.
2. Config fizz=2, buzz=3, len=7 in IDLE, then start with out_ready toggling 1,0,0,1,... -> codes 11,00,01,10,01,00,11 in order; values stable during stalls; no duplicate or skipped index.
3. cfg_we with cfg_fizz=0 in IDLE, and any cfg_we while busy -> cfg_err one-cycle pulse each time; readback by a later run shows the previous values.
4. pause=1 on the transfer of index 10 -> out_valid=0 the next cycle; after pause drops, index 11 is presented with the correct code. abort while stalled at index 20 -> IDLE, no done; a new start begins at index 0, code 11.
5. len=1, with fizz=buzz=1 -> single beat index 0 code 11, then done. start and abort together in IDLE -> stays IDLE, out_valid stays 0.
6. resetn driven low mid-run between clock edges -> out_valid, busy and done are 0 immediately; config returns to 3/5/100.

Source files
------------

// File: rtl/fizzbuzz_sequencer_if.sv
// Token stream interface of the fizz/buzz sequencer: one token per beat,
// with a valid/ready handshake so the sink can apply backpressure.
interface fizzbuzz_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_index;
  logic [1:0]       out_code;

  // The sequencer drives the token and its valid flag.
  modport master (
    output out_valid,
    output out_index,
    output out_code,
    input  out_ready
  );

  // The sink observes the token and drives ready.
  modport slave (
    input  out_valid,
    input  out_index,
    input  out_code,
    output out_ready
  );
endinterface

// File: rtl/fizzbuzz_sequencer.sv
// Run controller for the fizz/buzz classifier. It holds the programmable
// divisors and run length, walks an index from 0 to len-1 on start, and
// emits one classification token per index over a valid/ready stream.
// Divisibility is tracked with residue counters, so no divider is needed.
module fizzbuzz_sequencer #(
  parameter int CNT_W    = 8,
  parameter int DIV_W    = 4,
  parameter int FIZZ_RST = 3,
  parameter int BUZZ_RST = 5,
  parameter int LEN_RST  = 100
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cfg_we,
  input  logic [DIV_W-1:0]      cfg_fizz,
  input  logic [DIV_W-1:0]      cfg_buzz,
  input  logic [CNT_W-1:0]      cfg_len,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  pause,
  fizzbuzz_sequencer_if.master  out_if,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] fizz_q, fizz_d;
  logic [DIV_W-1:0] buzz_q, buzz_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] index_q, index_d;
  logic [DIV_W-1:0] fres_q, fres_d;
  logic [DIV_W-1:0] bres_q, bres_d;
  logic             valid_q, valid_d;
  logic [1:0]       code_q, code_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cfg_err_q, cfg_err_d;

  logic             cfg_ok;
  logic             xfer;
  logic             last_beat;
  logic [DIV_W-1:0] fres_next;
  logic [DIV_W-1:0] bres_next;

  // Next-state logic: configuration acceptance, run sequencing, the
  // handshake, pause at beat boundaries and abort. All outputs are
  // computed here and registered, so no input reaches an output directly.
  always_comb begin
    state_d   = state_q;
    fizz_d    = fizz_q;
    buzz_d    = buzz_q;
    len_d     = len_q;
    index_d   = index_q;
    fres_d    = fres_q;
    bres_d    = bres_q;
    valid_d   = valid_q;
    code_d    = code_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;

    cfg_ok    = (cfg_fizz != '0) && (cfg_buzz != '0) && (cfg_len != '0);
    xfer      = valid_q && out_if.out_ready;
    last_beat = (index_q == (len_q - CNT_W'(1)));
    fres_next = (fres_q == (fizz_q - DIV_W'(1))) ? '0 : (fres_q + DIV_W'(1));
    bres_next = (bres_q == (buzz_q - DIV_W'(1))) ? '0 : (bres_q + DIV_W'(1));

    if (cfg_we) begin
      if ((state_q == IDLE) && cfg_ok) begin
        fizz_d = cfg_fizz;
        buzz_d = cfg_buzz;
        len_d  = cfg_len;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = RUN;
          index_d = '0;
          fres_d  = '0;
          bres_d  = '0;
          code_d  = 2'b11;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end

      RUN: begin
        if (abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (xfer) begin
          if (last_beat) begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            index_d = index_q + CNT_W'(1);
            fres_d  = fres_next;
            bres_d  = bres_next;
            code_d  = {(bres_next == '0), (fres_next == '0)};
            if (pause) begin
              state_d = PAUSE;
              valid_d = 1'b0;
            end
          end
        end
      end

      PAUSE: begin
        if (abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (!pause) begin
          state_d = RUN;
          valid_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, configuration and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      fizz_q    <= DIV_W'(FIZZ_RST);
      buzz_q    <= DIV_W'(BUZZ_RST);
      len_q     <= CNT_W'(LEN_RST);
      index_q   <= '0;
      fres_q    <= '0;
      bres_q    <= '0;
      valid_q   <= 1'b0;
      code_q    <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fizz_q    <= fizz_d;
      buzz_q    <= buzz_d;
      len_q     <= len_d;
      index_q   <= index_d;
      fres_q    <= fres_d;
      bres_q    <= bres_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign out_if.out_valid = valid_q;
  assign out_if.out_index = index_q;
  assign out_if.out_code  = code_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign cfg_err          = cfg_err_q;

endmodule

// File: tb/tb_fizzbuzz_sequencer.sv
// Bench for the fizz/buzz sequencer: a table of configurations and run
// scenarios, randomized configurations and ready patterns, and hand-written
// sequences for busy writes, start+abort and asynchronous reset. Expected
// tokens come from plain modulo arithmetic on the index.
module tb_fizzbuzz_sequencer;
  localparam int CNT_W = 8;
  localparam int DIV_W = 4;

  logic             clk = 1'b0;
  logic             resetn = 1'b1;
  logic             cfg_we = 1'b0;
  logic [DIV_W-1:0] cfg_fizz = '0;
  logic [DIV_W-1:0] cfg_buzz = '0;
  logic [CNT_W-1:0] cfg_len = '0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             pause = 1'b0;
  logic             busy;
  logic             done;
  logic             cfg_err;

  fizzbuzz_sequencer_if #(.CNT_W(CNT_W)) out_if();

  fizzbuzz_sequencer #(
    .CNT_W(CNT_W), .DIV_W(DIV_W), .FIZZ_RST(3), .BUZZ_RST(5), .LEN_RST(100)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .cfg_we   (cfg_we),
    .cfg_fizz (cfg_fizz),
    .cfg_buzz (cfg_buzz),
    .cfg_len  (cfg_len),
    .start    (start),
    .abort    (abort),
    .pause    (pause),
    .out_if   (out_if),
    .busy     (busy),
    .done     (done),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model of the configuration the next run must use.
  int mFizz = 3;
  int mBuzz = 5;
  int mLen  = 100;

  typedef struct {
    int fz;
    int bz;
    int len;
    bit sameCycle;
    bit expErr;
    int readyMode;
    int pauseIdx;
    int abortIdx;
    bit abortReady;
  } vec_t;

  vec_t tbl[9];

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Expected token class from the divisibility rules.
  function automatic int refCode(input int idx, input int fz, input int bz);
    return (((idx % bz) == 0) ? 2 : 0) + (((idx % fz) == 0) ? 1 : 0);
  endfunction

  // Drive one cycle of control inputs at the falling edge, then release.
  task automatic applyStimulus(input bit we, input int fz, input int bz, input int len,
                               input bit st, input bit ab);
    @(negedge clk);
    cfg_we   = we;
    cfg_fizz = DIV_W'(fz);
    cfg_buzz = DIV_W'(bz);
    cfg_len  = CNT_W'(len);
    start    = st;
    abort    = ab;
    @(negedge clk);
    cfg_we   = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
  endtask

  // Write a configuration (separately or with start) and launch a run.
  task automatic startRun(input bit sameCycle, input int fz, input int bz, input int len,
                          input bit expErr);
    if (sameCycle) begin
      applyStimulus(1'b1, fz, bz, len, 1'b1, 1'b0);
      checkOutput("start_cfg_err", cfg_err, expErr);
    end else begin
      applyStimulus(1'b1, fz, bz, len, 1'b0, 1'b0);
      checkOutput("write_cfg_err", cfg_err, expErr);
      checkOutput("write_idle_valid", out_if.out_valid, 0);
      applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b0);
      checkOutput("start_err_low", cfg_err, 0);
    end
    if (!expErr) begin
      mFizz = fz;
      mBuzz = bz;
      mLen  = len;
    end
  endtask

  // Follow a run from its first beat until done or abort, checking every
  // cycle against the expected token sequence and handshake behaviour.
  task automatic streamCheck(input int readyMode, input int pauseIdx, input int abortIdx,
                             input bit abortReady);
    int  nextIdx  = 0;
    int  cyc      = 0;
    int  holdCnt  = 0;
    int  stallCnt = 0;
    bit  expValid = 1'b1;
    bit  curValid;
    bit  isPaused = 1'b0;
    bit  finished = 1'b0;
    bit  endDone  = 1'b0;
    bit  endAbort = 1'b0;
    bit  prevStall = 1'b0;
    bit  rdy;
    logic [CNT_W-1:0] prevIdx = '0;
    logic [1:0]       prevCode = '0;
    while (!finished) begin
      if (cyc >= 3000) begin
        checks++;
        errors++;
        $display("[TB] FAIL cycle_budget: run did not end, index %0d", nextIdx);
        finished = 1'b1;
      end else begin
        curValid = expValid;
        checkOutput("busy_in_run", busy, 1);
        checkOutput("valid", out_if.out_valid, curValid);
        checkOutput("done_low", done, 0);
        if (cyc > 0) checkOutput("cfg_err_low", cfg_err, 0);
        if (curValid) begin
          checkOutput("index", out_if.out_index, nextIdx);
          checkOutput("code", out_if.out_code, refCode(nextIdx, mFizz, mBuzz));
        end
        if (prevStall) begin
          checkOutput("stall_index", out_if.out_index, prevIdx);
          checkOutput("stall_code", out_if.out_code, prevCode);
        end
        prevIdx  = out_if.out_index;
        prevCode = out_if.out_code;

        case (readyMode)
          0:       rdy = 1'b1;
          1:       rdy = ((cyc % 3) == 0);
          default: rdy = 1'b1 & ($urandom_range(0, 1) == 1);
        endcase
        start = (readyMode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
        abort = 1'b0;
        pause = 1'b0;

        if (isPaused) begin
          if (holdCnt > 0) begin
            pause   = 1'b1;
            holdCnt = holdCnt - 1;
          end else begin
            isPaused = 1'b0;
            expValid = 1'b1;
          end
        end else if (nextIdx == abortIdx) begin
          if (stallCnt < 2) begin
            rdy      = 1'b0;
            stallCnt = stallCnt + 1;
          end else begin
            abort    = 1'b1;
            rdy      = abortReady;
            endAbort = 1'b1;
          end
        end else if (rdy) begin
          if (nextIdx == mLen - 1) begin
            if (pauseIdx == nextIdx) pause = 1'b1;
            endDone = 1'b1;
          end else begin
            if (nextIdx == pauseIdx) begin
              pause    = 1'b1;
              isPaused = 1'b1;
              holdCnt  = 2;
              expValid = 1'b0;
            end
            nextIdx = nextIdx + 1;
          end
        end
        out_if.out_ready = rdy;
        prevStall = curValid && !rdy && !endAbort;

        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        pause = 1'b0;
        cyc   = cyc + 1;

        if (endDone) begin
          checkOutput("done_pulse", done, 1);
          checkOutput("done_valid", out_if.out_valid, 0);
          checkOutput("done_busy", busy, 0);
          @(negedge clk);
          checkOutput("done_one_cycle", done, 0);
          checkOutput("idle_busy", busy, 0);
          finished = 1'b1;
        end else if (endAbort) begin
          checkOutput("abort_valid", out_if.out_valid, 0);
          checkOutput("abort_busy", busy, 0);
          checkOutput("abort_no_done", done, 0);
          @(negedge clk);
          checkOutput("abort_no_done_later", done, 0);
          finished = 1'b1;
        end
      end
    end
  endtask

  initial begin
    out_if.out_ready = 1'b1;

    // Reset state.
    #1 resetn = 1'b0;
    #2;
    checkOutput("rst_valid", out_if.out_valid, 0);
    checkOutput("rst_index", out_if.out_index, 0);
    checkOutput("rst_code", out_if.out_code, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_cfg_err", cfg_err, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Default configuration: 100 beats with ready held high.
    $display("[TB] default run");
    applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b0);
    streamCheck(0, -1, -1, 1'b0);

    // Table of configurations and run scenarios.
    tbl[0] = '{2, 3, 7, 1'b0, 1'b0, 1, -1, -1, 1'b0};
    tbl[1] = '{0, 3, 7, 1'b0, 1'b1, 0, -1, -1, 1'b0};
    tbl[2] = '{1, 1, 1, 1'b1, 1'b0, 0, -1, -1, 1'b0};
    tbl[3] = '{4, 0, 9, 1'b1, 1'b1, 2, -1, -1, 1'b0};
    tbl[4] = '{3, 5, 30, 1'b0, 1'b0, 2, 10, -1, 1'b0};
    tbl[5] = '{3, 5, 0, 1'b1, 1'b1, 0, 29, -1, 1'b0};
    tbl[6] = '{7, 4, 40, 1'b0, 1'b0, 2, -1, 20, 1'b0};
    tbl[7] = '{6, 9, 25, 1'b1, 1'b0, 0, -1, 5, 1'b1};
    tbl[8] = '{15, 15, 255, 1'b0, 1'b0, 2, 100, -1, 1'b0};
    for (int i = 0; i < 9; i++) begin
      $display("[TB] table entry %0d", i);
      startRun(tbl[i].sameCycle, tbl[i].fz, tbl[i].bz, tbl[i].len, tbl[i].expErr);
      streamCheck(tbl[i].readyMode, tbl[i].pauseIdx, tbl[i].abortIdx, tbl[i].abortReady);
    end

    // Configuration write while busy is rejected and leaves config intact.
    $display("[TB] busy write");
    out_if.out_ready = 1'b0;
    applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1, 1, 1, 1'b0, 1'b0);
    checkOutput("busy_cfg_err", cfg_err, 1);
    checkOutput("busy_write_valid", out_if.out_valid, 1);
    checkOutput("busy_write_index", out_if.out_index, 0);
    @(negedge clk);
    checkOutput("busy_cfg_err_pulse", cfg_err, 0);
    applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b1);
    checkOutput("busy_abort_valid", out_if.out_valid, 0);
    applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b0);
    streamCheck(2, -1, -1, 1'b0);

    // Start and abort together in IDLE stay idle.
    $display("[TB] start with abort");
    applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b1);
    checkOutput("sa_valid", out_if.out_valid, 0);
    checkOutput("sa_busy", busy, 0);
    @(negedge clk);
    checkOutput("sa_valid_later", out_if.out_valid, 0);

    // Randomized configurations and scenarios.
    for (int r = 0; r < 8; r++) begin
      int fz, bz, len, pIdx, aIdx;
      bit same, err;
      fz   = $urandom_range(0, 15);
      bz   = $urandom_range(0, 15);
      len  = $urandom_range(0, 50);
      if ($urandom_range(0, 7) == 0) fz = 0;
      same = ($urandom_range(0, 1) == 1);
      err  = (fz == 0) || (bz == 0) || (len == 0);
      $display("[TB] random run %0d fizz %0d buzz %0d len %0d", r, fz, bz, len);
      startRun(same, fz, bz, len, err);
      pIdx = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, mLen - 1)) : -1;
      aIdx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, mLen - 1)) : -1;
      streamCheck(2, pIdx, aIdx, ($urandom_range(0, 1) == 1));
    end

    // Asynchronous reset mid-run returns everything to defaults.
    $display("[TB] async reset");
    out_if.out_ready = 1'b0;
    applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b0);
    checkOutput("prereset_valid", out_if.out_valid, 1);
    #2 resetn = 1'b0;
    #1;
    checkOutput("arst_valid", out_if.out_valid, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_done", done, 0);
    @(negedge clk);
    resetn = 1'b1;
    mFizz = 3;
    mBuzz = 5;
    mLen  = 100;
    applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b0);
    streamCheck(0, -1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
